// File: rtl/wb_apb_bridge.sv
// Wishbone B4 slave (classic + pipelined) to APB4 requester bridge.
// Each accepted WB strobe becomes exactly one APB transfer.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-low reset
//   adr_i, dat_i, sel_i    WB request address / write data / byte selects
//   we_i, cyc_i, stb_i     WB direction, cycle and strobe
//   dat_o                  WB read data (holds the last completed read)
//   ack_o, err_o           WB normal / error termination, one cycle each
//   stall_o                WB pipelined stall, high whenever not idle
//   paddr_o .. pstrb_o     APB request side
//   prdata_i, pready_i,
//   pslverr_i              APB completion side
//
// Flow: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
// Misaligned or empty-select requests skip the APB and go IDLE -> RESP.
module wb_apb_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int GRANULE        = 8,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int SEL_WIDTH     = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic                  we_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [SEL_WIDTH-1:0]  pstrb_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    // Low address bits that must be zero for a lane-aligned access.
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'(SEL_WIDTH - 1);

    // Counter wide enough to reach TIMEOUT_CYCLES; one bit when disabled.
    localparam int TW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  abort_q, abort_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;

    logic                  req_bad;
    logic [TW-1:0]         tcnt_nxt;

    assign req_bad  = (sel_i == '0) || ((adr_i & OFF_MASK) != '0);
    assign tcnt_nxt = tcnt_q + TW'(1);

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        abort_d = abort_q;
        tcnt_d  = tcnt_q;

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                tcnt_d  = '0;
                if (cyc_i && stb_i) begin
                    adr_d   = adr_i;
                    dat_d   = dat_i;
                    sel_d   = sel_i;
                    we_d    = we_i;
                    err_d   = req_bad;
                    state_d = req_bad ? RESP : SETUP;
                end
            end

            SETUP: begin
                // APB cannot be aborted; remember the master left.
                if (!cyc_i) begin
                    abort_d = 1'b1;
                end
                tcnt_d  = '0;
                state_d = ACCESS;
            end

            ACCESS: begin
                if (!cyc_i) begin
                    abort_d = 1'b1;
                end
                // A completing slave wins over an expiring timeout.
                if (pready_i) begin
                    if (!we_q) begin
                        rdata_d = prdata_i;
                    end
                    err_d   = pslverr_i;
                    state_d = RESP;
                end else if (TO_EN && (tcnt_nxt == TMAX)) begin
                    err_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_nxt;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    assign stall_o   = (state_q != IDLE);
    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign ack_o     = (state_q == RESP) && !err_q && !abort_q;
    assign err_o     = (state_q == RESP) && err_q && !abort_q;

    assign paddr_o   = adr_q;
    assign pwrite_o  = we_q;
    assign pwdata_o  = dat_q;
    assign pstrb_o   = we_q ? sel_q : '0;
    assign dat_o     = rdata_q;

endmodule
